// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V pipeline stages.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; valid marks a real instruction.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int          XLEN      = riscv_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            flush,
  input  logic            stall,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_o    <= NOP_INSTR;
      pc_o       <= '0;
      pc_plus4_o <= '0;
      valid_o    <= 1'b0;
    end else if (en) begin
      if (flush) begin
        instr_o    <= NOP_INSTR;
        pc_o       <= '0;
        pc_plus4_o <= '0;
        valid_o    <= 1'b0;
      end else if (!stall) begin
        instr_o    <= instr_i;
        pc_o       <= pc_i;
        pc_plus4_o <= pc_plus4_i;
        valid_o    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, PC+4 adder, boot FSM, IF/ID register and fetch counter.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::DEFAULT_RESET_PC),
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_next_i,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  output logic [XLEN-1:0] pc_f_o,
  output logic [XLEN-1:0] pc_plus4_f_o,
  output logic [31:0]     instr_d_o,
  output logic [XLEN-1:0] pc_d_o,
  output logic [XLEN-1:0] pc_plus4_d_o,
  output logic            valid_d_o,
  output logic [31:0]     fetch_count_o,
  output fetch_state_t    fsm_state_o
);

  // Stall semantics: stall_f/stall_d hold their register for the edge, flush_d
  // overrides stall_d; valid_d_o is high only when IF/ID holds a fetched word.
  fetch_state_t    state;
  logic [XLEN-1:0] pc_f;
  logic [31:0]     fetch_count;
  logic            run;
  logic            load_d;

  assign run    = (state == RUN);
  assign load_d = run && !flush_d && !stall_d;

  // BOOT swallows the first edge after reset so the memory sees RESET_PC for a full cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc_f        <= RESET_PC;
      fetch_count <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          state <= RUN;
          if (!stall_f) pc_f <= pc_next_i & ~XLEN'(3);
          if (load_d) fetch_count <= fetch_count + 32'd1;
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign imem_addr_o   = pc_f;
  assign pc_f_o        = pc_f;
  assign pc_plus4_f_o  = pc_f + XLEN'(4);
  assign fetch_count_o = fetch_count;
  assign fsm_state_o   = state;

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (run),
    .flush      (flush_d),
    .stall      (stall_d),
    .instr_i    (imem_rdata_i),
    .pc_i       (pc_f),
    .pc_plus4_i (pc_plus4_f_o),
    .instr_o    (instr_d_o),
    .pc_o       (pc_d_o),
    .pc_plus4_o (pc_plus4_d_o),
    .valid_o    (valid_d_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed plan plus randomized run against a behavioural model.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] pc_next_i = '0;
  logic         stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0;
  logic [W-1:0] imem_addr_o, pc_f_o, pc_plus4_f_o, pc_d_o, pc_plus4_d_o;
  logic [31:0]  imem_rdata_i, instr_d_o, fetch_count_o;
  logic         valid_d_o;
  fetch_state_t fsm_state_o;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_next_i     (pc_next_i),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .pc_f_o        (pc_f_o),
    .pc_plus4_f_o  (pc_plus4_f_o),
    .instr_d_o     (instr_d_o),
    .pc_d_o        (pc_d_o),
    .pc_plus4_d_o  (pc_plus4_d_o),
    .valid_d_o     (valid_d_o),
    .fetch_count_o (fetch_count_o),
    .fsm_state_o   (fsm_state_o)
  );

  // Instruction memory: fixed word at 0, address-hashed content elsewhere.
  function automatic logic [31:0] mem_word(input logic [W-1:0] a);
    if (a == '0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction
  assign imem_rdata_i = mem_word(imem_addr_o);

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_pc, m_pcd, m_pc4d;
  logic [31:0]  m_instr, m_cnt;
  logic         m_valid, m_boot;
  logic         chk_en = 1'b0;

  task automatic model_reset();
    m_pc = '0; m_pcd = '0; m_pc4d = '0; m_instr = 32'h13;
    m_cnt = '0; m_valid = 1'b0; m_boot = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_boot) begin
        m_boot = 1'b0;
      end else begin
        logic [W-1:0] old_pc;
        old_pc = m_pc;
        if (!stall_f) m_pc = (pc_next_i / 4) * 4;
        if (flush_d) begin
          m_instr = 32'h13; m_pcd = '0; m_pc4d = '0; m_valid = 1'b0;
        end else if (!stall_d) begin
          m_instr = mem_word(old_pc); m_pcd = old_pc; m_pc4d = old_pc + 4;
          m_valid = 1'b1; m_cnt = m_cnt + 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr", imem_addr_o, m_pc);
      chk("pc_f", pc_f_o, m_pc);
      chk("pc_plus4_f", pc_plus4_f_o, m_pc + 32'd4);
      chk("instr_d", instr_d_o, m_instr);
      chk("pc_d", pc_d_o, m_pcd);
      chk("pc_plus4_d", pc_plus4_d_o, m_pc4d);
      chk("valid_d", {31'b0, valid_d_o}, {31'b0, m_valid});
      chk("fetch_count", fetch_count_o, m_cnt);
      chk("state", {31'b0, fsm_state_o == RUN}, {31'b0, !m_boot});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] nxt, input logic sf, input logic sd, input logic fd);
    pc_next_i = nxt; stall_f = sf; stall_d = sd; flush_d = fd;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    drive(32'h4, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1. reset and boot
    chk("rst_pc_f", pc_f_o, 32'h0);
    chk("rst_instr", instr_d_o, 32'h13);
    chk("rst_valid", {31'b0, valid_d_o}, 32'h0);
    tick();
    chk("boot_pc_f", pc_f_o, 32'h0);
    chk("boot_valid", {31'b0, valid_d_o}, 32'h0);
    tick();
    // 2. first real fetch
    chk("run_pc_f", pc_f_o, 32'h4);
    chk("run_instr", instr_d_o, 32'h0050_0093);
    chk("run_pc_d", pc_d_o, 32'h0);
    chk("run_pc4_d", pc_plus4_d_o, 32'h4);
    chk("run_valid", {31'b0, valid_d_o}, 32'h1);
    chk("run_count", fetch_count_o, 32'd1);
    drive(32'h8, 1'b0, 1'b0, 1'b0);
    tick();
    chk("seq_pc_f", pc_f_o, 32'h8);
    chk("seq_count", fetch_count_o, 32'd2);

    // 3. stall for three cycles
    drive(32'hC, 1'b1, 1'b1, 1'b0);
    repeat (3) begin
      tick();
      chk("stall_pc_f", pc_f_o, 32'h8);
      chk("stall_pc_d", pc_d_o, 32'h4);
      chk("stall_count", fetch_count_o, 32'd2);
    end
    drive(32'hC, 1'b0, 1'b0, 1'b0);
    tick();
    chk("resume_pc_f", pc_f_o, 32'hC);
    chk("resume_pc_d", pc_d_o, 32'h8);
    chk("resume_count", fetch_count_o, 32'd3);

    // 4. redirect with flush, flush+stall_d, flush+stall_f
    drive(32'h40, 1'b0, 1'b0, 1'b1);
    tick();
    chk("flush_pc_f", pc_f_o, 32'h40);
    chk("flush_instr", instr_d_o, 32'h13);
    chk("flush_valid", {31'b0, valid_d_o}, 32'h0);
    chk("flush_count", fetch_count_o, 32'd3);
    drive(32'h44, 1'b0, 1'b1, 1'b1);
    tick();
    chk("flush_sd_pc_f", pc_f_o, 32'h44);
    chk("flush_sd_valid", {31'b0, valid_d_o}, 32'h0);
    drive(32'h80, 1'b1, 1'b0, 1'b1);
    tick();
    chk("flush_sf_pc_f", pc_f_o, 32'h44);
    chk("flush_sf_pc_d", pc_d_o, 32'h0);
    drive(32'h48, 1'b0, 1'b0, 1'b0);
    tick();
    chk("after_flush_pc_d", pc_d_o, 32'h44);
    chk("after_flush_count", fetch_count_o, 32'd4);

    // 5. alignment and wrap
    drive(32'h23, 1'b0, 1'b0, 1'b0);
    tick();
    chk("align_pc_f", pc_f_o, 32'h20);
    drive(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    tick();
    chk("top_pc_f", pc_f_o, 32'hFFFF_FFFC);
    chk("wrap_pc4_f", pc_plus4_f_o, 32'h0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("wrap_pc_d", pc_d_o, 32'hFFFF_FFFC);
    chk("wrap_pc4_d", pc_plus4_d_o, 32'h0);

    // 6. async reset between edges
    drive(32'h40, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_rst_pc_f", pc_f_o, 32'h40);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_pc_f", pc_f_o, 32'h0);
    chk("arst_instr", instr_d_o, 32'h13);
    chk("arst_valid", {31'b0, valid_d_o}, 32'h0);
    chk("arst_count", fetch_count_o, 32'h0);
    chk("arst_pc_d", pc_d_o, 32'h0);
    drive(32'h4, 1'b0, 1'b0, 1'b0);
    release_reset();
    tick();
    chk("reboot_pc_f", pc_f_o, 32'h0);
    tick();
    chk("reboot2_pc_f", pc_f_o, 32'h4);
    chk("reboot2_count", fetch_count_o, 32'd1);

    // Randomized phase, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] nxt;
      nxt = ($urandom_range(0, 3) == 0) ? W'($urandom) : m_pc + 32'd4;
      drive(nxt, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 6) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        model_reset();
        release_reset();
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
